// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: frame-rate game sequencer for the dino runner.
// Latches buttons, runs the game FSM, jump physics, score, speed and spawns.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   frame_tick      one-cycle pulse per frame; all game updates happen on it
//   btn_jump        jump/start button (level, already synchronised)
//   btn_duck        duck button (only used when DINO_DUCK_EN is defined)
//   collision       renderer reports dino/obstacle overlap this frame
//   game_state      0=IDLE 1=RUN 2=AIR 3=OVER
//   dino_y          dino height above ground in pixels
//   dino_duck       dino drawn ducking
//   score           frames survived, saturating
//   speed           scroll speed, 0 in IDLE, 1..7 while playing
//   obstacle_spawn  one-cycle pulse telling the renderer to start an obstacle
//
// Build option: define DINO_DUCK_EN to enable ducking in RUN.
// Without it btn_duck is ignored and dino_duck stays 0.

module dino_game_ctrl #(
    parameter int JUMP_V0    = 10,
    parameter int GRAVITY    = 1,
    parameter int SCORE_W    = 10,
    parameter int SPEED_STEP = 64,
    parameter int MIN_GAP    = 24,
    parameter int OVER_HOLD  = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_jump,
    input  logic               btn_duck,
    input  logic               collision,
    output logic [1:0]         game_state,
    output logic [5:0]         dino_y,
    output logic               dino_duck,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         speed,
    output logic               obstacle_spawn
);

    localparam int SPW = $clog2(MIN_GAP + 32);
    localparam int HW  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_AIR  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t              r_state;
    logic [5:0]          r_y;
    logic signed [6:0]   r_vel;
    logic                r_duck;
    logic [SCORE_W-1:0]  r_score;
    logic [2:0]          r_speed;
    logic                r_spawn;
    logic [SPW-1:0]      r_spawn_cnt;
    logic [HW-1:0]       r_hold;
    logic                r_jump;
    logic [7:0]          r_lfsr;

    state_t              w_state_nxt;
    logic [5:0]          w_y_nxt;
    logic signed [6:0]   w_vel_nxt;
    logic                w_duck_nxt;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [2:0]          w_speed_nxt;
    logic                w_spawn_nxt;
    logic [SPW-1:0]      w_cnt_nxt;
    logic [HW-1:0]       w_hold_nxt;
    logic                w_start;
    logic                w_play;
    logic                w_jump;
    logic                w_duck_req;
    logic signed [6:0]   w_y_sum;
    logic [SCORE_W-1:0]  w_score_inc;
    logic                w_step_hit;
    logic                w_lfsr_fb;

    // A press in the tick cycle itself still counts for that frame.
    assign w_jump = r_jump | btn_jump;

`ifdef DINO_DUCK_EN
    assign w_duck_req = btn_duck;
`else
    logic w_unused_duck;
    assign w_unused_duck = btn_duck;
    assign w_duck_req    = 1'b0;
`endif

    assign w_y_sum     = $signed({1'b0, r_y}) + r_vel;
    assign w_score_inc = r_score + 1'b1;
    assign w_step_hit  =
        ((32'(w_score_inc) & 32'(SPEED_STEP - 1)) == 32'd0);
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        w_duck_nxt  = r_duck;
        w_score_nxt = r_score;
        w_speed_nxt = r_speed;
        w_spawn_nxt = 1'b0;
        w_cnt_nxt   = r_spawn_cnt;
        w_hold_nxt  = r_hold;
        w_start     = 1'b0;
        w_play      = 1'b0;

        if (frame_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_jump) w_start = 1'b1;
                end
                S_RUN: begin
                    // Collision freezes the frame it happens in.
                    if (collision) begin
                        w_state_nxt = S_OVER;
                        w_hold_nxt  = HW'(OVER_HOLD);
                    end else begin
                        w_play = 1'b1;
                        if (w_jump && !w_duck_req) begin
                            w_state_nxt = S_AIR;
                            w_vel_nxt   = 7'(JUMP_V0);
                        end
                    end
                end
                S_AIR: begin
                    if (collision) begin
                        w_state_nxt = S_OVER;
                        w_hold_nxt  = HW'(OVER_HOLD);
                    end else begin
                        w_play    = 1'b1;
                        w_vel_nxt = r_vel - 7'(GRAVITY);
                        if (r_vel < 7'sd0 && w_y_sum <= 7'sd0) begin
                            w_state_nxt = S_RUN;
                            w_y_nxt     = 6'd0;
                            w_vel_nxt   = 7'sd0;
                        end else begin
                            w_y_nxt = w_y_sum[5:0];
                        end
                    end
                end
                S_OVER: begin
                    if (r_hold == '0) begin
                        if (w_jump) w_start = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold - 1'b1;
                    end
                end
            endcase

            // Entry tick counts as the first frame survived.
            if (w_start) begin
                w_state_nxt = S_RUN;
                w_y_nxt     = 6'd0;
                w_vel_nxt   = 7'sd0;
                w_score_nxt = SCORE_W'(1);
                w_speed_nxt = 3'd1;
                w_cnt_nxt   = SPW'(MIN_GAP);
            end

            if (w_play) begin
                if (r_score != '1) begin
                    w_score_nxt = w_score_inc;
                    if (w_step_hit && r_speed != 3'd7)
                        w_speed_nxt = r_speed + 3'd1;
                end
                // Reload value equals the gap to the next pulse.
                if (r_spawn_cnt <= SPW'(1)) begin
                    w_spawn_nxt = 1'b1;
                    w_cnt_nxt   = SPW'(MIN_GAP) + SPW'(r_lfsr[4:0]);
                end else begin
                    w_cnt_nxt = r_spawn_cnt - 1'b1;
                end
            end

            w_duck_nxt = (w_state_nxt == S_RUN) && w_duck_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= 6'd0;
            r_vel       <= 7'sd0;
            r_duck      <= 1'b0;
            r_score     <= '0;
            r_speed     <= 3'd0;
            r_spawn     <= 1'b0;
            r_spawn_cnt <= '0;
            r_hold      <= '0;
            r_jump      <= 1'b0;
            r_lfsr      <= 8'hA5;
        end else begin
            r_state     <= w_state_nxt;
            r_y         <= w_y_nxt;
            r_vel       <= w_vel_nxt;
            r_duck      <= w_duck_nxt;
            r_score     <= w_score_nxt;
            r_speed     <= w_speed_nxt;
            r_spawn     <= w_spawn_nxt;
            r_spawn_cnt <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_jump      <= frame_tick ? 1'b0 : w_jump;
            r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign game_state     = r_state;
    assign dino_y         = r_y;
    assign dino_duck      = r_duck;
    assign score          = r_score;
    assign speed          = r_speed;
    assign obstacle_spawn = r_spawn;

endmodule
